// File: rtl/anspwm_sequencer.sv
// anspwm_sequencer
// Frame-rate sample sequencer for the ANS PWM quantizer pipeline.
// Buffers one incoming 32-bit target sample. Once per PWM frame it launches
// a sample onto pipe_a. After LATENCY clocks it captures the signed 16-bit
// pipeline result as the duty word for the PWM generator.
//
// Ports
//   clk, rst_n     system clock (rising edge), async active-low reset
//   en             synchronous run enable; low forces IDLE and drops pending
//   in_valid/in_ready/in_data   sample source handshake (in_ready is combinational)
//   pipe_a         registered target sample to stage 1 A input
//   pipe_c/pipe_csgn   pipeline result magnitude / sign
//   frame_start    one-cycle pulse in the first cycle of each frame
//   duty/duty_sgn  captured result; duty_valid pulses when they update
//   underrun_cnt   frames launched without a fresh sample (saturating)
//   busy           sequencer not idle
module anspwm_sequencer #(
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic [31:0] pipe_a,
   input  logic [15:0] pipe_c,
   input  logic        pipe_csgn,
   output logic        frame_start,
   output logic [15:0] duty,
   output logic        duty_sgn,
   output logic        duty_valid,
   output logic [7:0]  underrun_cnt,
   output logic        busy
);

   localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned LCNT_W = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DUTY_W = 16;
   localparam int unsigned UR_W   = 8;

   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
   localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LATENCY - 1);
   localparam logic [UR_W-1:0]   UR_MAX    = UR_W'(255);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [FCNT_W-1:0]   fcnt, fcnt_nxt;
   logic [LCNT_W-1:0]   lcnt, lcnt_nxt;
   logic [DATA_W-1:0]   pend, pend_nxt;
   logic                pend_v, pend_v_nxt;
   logic [DATA_W-1:0]   pipe_a_nxt;
   logic [DUTY_W-1:0]   duty_nxt;
   logic                duty_sgn_nxt;
   logic [UR_W-1:0]     ur_nxt;
   logic                capture;
   logic                frame_end;
   logic                launch;
   logic                accept;

   // Launch is decided without in_ready so the handshake has no comb loop.
   // In IDLE the pending buffer is always empty, so in_valid alone accepts.
   assign frame_end = (state == S_HOLD) && (fcnt == FCNT_LAST);
   assign launch    = en && (((state == S_IDLE) && in_valid) || frame_end);
   assign in_ready  = en && (!pend_v || launch);
   assign accept    = in_valid && in_ready;

   // Next-state, datapath next values and capture strobe.
   always_comb begin
      state_nxt    = state;
      fcnt_nxt     = fcnt;
      lcnt_nxt     = lcnt;
      pend_nxt     = pend;
      pend_v_nxt   = pend_v;
      pipe_a_nxt   = pipe_a;
      duty_nxt     = duty;
      duty_sgn_nxt = duty_sgn;
      ur_nxt       = underrun_cnt;
      capture      = 1'b0;

      if (!en) begin
         // Abandon everything in flight; results and pipe_a keep their values.
         state_nxt  = S_IDLE;
         fcnt_nxt   = '0;
         lcnt_nxt   = '0;
         pend_v_nxt = 1'b0;
      end else begin
         if (state != S_IDLE) begin
            fcnt_nxt = (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               // First sample after idle bypasses the pending buffer.
               if (accept) begin
                  pipe_a_nxt = in_data;
               end
            end

            S_WAIT: begin
               if (accept) begin
                  pend_nxt   = in_data;
                  pend_v_nxt = 1'b1;
               end
               if (lcnt == LCNT_LAST) begin
                  capture      = 1'b1;
                  duty_nxt     = pipe_c;
                  duty_sgn_nxt = pipe_csgn;
                  state_nxt    = S_HOLD;
               end else begin
                  lcnt_nxt = lcnt + 1'b1;
               end
            end

            S_HOLD: begin
               if (frame_end) begin
                  if (pend_v) begin
                     // Launch the buffered sample; a same-cycle accept refills it.
                     pipe_a_nxt = pend;
                     pend_v_nxt = accept;
                     if (accept) begin
                        pend_nxt = in_data;
                     end
                  end else if (accept) begin
                     pipe_a_nxt = in_data;
                  end else if (underrun_cnt != UR_MAX) begin
                     ur_nxt = underrun_cnt + 1'b1;
                  end
               end else if (accept) begin
                  pend_nxt   = in_data;
                  pend_v_nxt = 1'b1;
               end
            end

            default: begin
               state_nxt = S_IDLE;
            end
         endcase

         // Every launch (including an underrun) restarts frame and latency timing.
         if (launch) begin
            state_nxt = S_WAIT;
            fcnt_nxt  = '0;
            lcnt_nxt  = '0;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         fcnt         <= '0;
         lcnt         <= '0;
         pend         <= '0;
         pend_v       <= 1'b0;
         pipe_a       <= '0;
         duty         <= '0;
         duty_sgn     <= 1'b0;
         duty_valid   <= 1'b0;
         frame_start  <= 1'b0;
         underrun_cnt <= '0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         fcnt         <= fcnt_nxt;
         lcnt         <= lcnt_nxt;
         pend         <= pend_nxt;
         pend_v       <= pend_v_nxt;
         pipe_a       <= pipe_a_nxt;
         duty         <= duty_nxt;
         duty_sgn     <= duty_sgn_nxt;
         duty_valid   <= capture;
         frame_start  <= launch;
         underrun_cnt <= ur_nxt;
         busy         <= (state_nxt != S_IDLE);
      end
   end

endmodule
